// File: rtl/ext_mem_loader.sv
// External data-memory initiator: LOAD streams in_* words into memory, DUMP reads
// consecutive words back out on out_* through a one-entry output register.
module ext_mem_loader #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_val,
   output logic             cmd_rdy,
   input  logic             cmd_op,
   input  logic [31:0]      cmd_base,
   input  logic [CNT_W-1:0] cmd_count,
   input  logic             in_val,
   output logic             in_rdy,
   input  logic [31:0]      in_data,
   output logic             out_val,
   input  logic             out_rdy,
   output logic [31:0]      out_data,
   output logic             ext_dmemreq_val,
   output logic             ext_dmemreq_type,
   output logic [31:0]      ext_dmemreq_addr,
   output logic [31:0]      ext_dmemreq_wdata,
   input  logic [31:0]      ext_dmemreq_rdata,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DUMP, S_FIN} state_t;

   state_t           state_q, state_d;
   logic [31:0]      addr_q, addr_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic             out_val_q, out_val_d;
   logic [31:0]      out_data_q, out_data_d;
   logic             rd_issue;

   always_comb begin
      state_d           = state_q;
      addr_d            = addr_q;
      rem_d             = rem_q;
      out_val_d         = out_val_q;
      out_data_d        = out_data_q;
      rd_issue          = 1'b0;
      in_rdy            = 1'b0;
      ext_dmemreq_val   = 1'b0;
      ext_dmemreq_type  = 1'b0;
      ext_dmemreq_addr  = 32'h0;
      ext_dmemreq_wdata = 32'h0;
      case (state_q)
         S_IDLE: begin
            if (cmd_val) begin
               addr_d = cmd_base & 32'hFFFF_FFFC;
               rem_d  = cmd_count;
               if (cmd_count == '0)  state_d = S_FIN;
               else if (cmd_op)      state_d = S_DUMP;
               else                  state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            in_rdy = 1'b1;
            if (in_val) begin
               ext_dmemreq_val   = 1'b1;
               ext_dmemreq_type  = 1'b1;
               ext_dmemreq_addr  = addr_q;
               ext_dmemreq_wdata = in_data;
               addr_d            = addr_q + 32'd4;
               rem_d             = rem_q - CNT_W'(1);
               if (rem_q == CNT_W'(1)) state_d = S_FIN;
            end
         end
         S_DUMP: begin
            // A read may refill the output register in the same cycle its word is taken.
            rd_issue = (rem_q != '0) && (!out_val_q || out_rdy);
            if (rd_issue) begin
               ext_dmemreq_val  = 1'b1;
               ext_dmemreq_addr = addr_q;
               out_data_d       = ext_dmemreq_rdata;
               out_val_d        = 1'b1;
               addr_d           = addr_q + 32'd4;
               rem_d            = rem_q - CNT_W'(1);
            end else if (out_val_q && out_rdy) begin
               out_val_d = 1'b0;
            end
            if ((rem_d == '0) && !out_val_d) state_d = S_FIN;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         addr_q     <= 32'h0;
         rem_q      <= '0;
         out_val_q  <= 1'b0;
         out_data_q <= 32'h0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         rem_q      <= rem_d;
         out_val_q  <= out_val_d;
         out_data_q <= out_data_d;
      end
   end

   assign out_val  = out_val_q;
   assign out_data = out_data_q;
   assign cmd_rdy  = (state_q == S_IDLE) && !rst;
   assign busy     = (state_q == S_LOAD) || (state_q == S_DUMP);
   assign done     = (state_q == S_FIN);

endmodule

// File: tb/tb_ext_mem_loader.sv
// Directed bench for ext_mem_loader with a small behavioural memory on the request port.
module tb_ext_mem_loader;

   logic        clk, rst;
   logic        cmd_val, cmd_rdy, cmd_op;
   logic [31:0] cmd_base;
   logic [15:0] cmd_count;
   logic        in_val, in_rdy;
   logic [31:0] in_data;
   logic        out_val, out_rdy;
   logic [31:0] out_data;
   logic        ext_dmemreq_val, ext_dmemreq_type;
   logic [31:0] ext_dmemreq_addr, ext_dmemreq_wdata, ext_dmemreq_rdata;
   logic        busy, done;

   int tests = 0;
   int fails = 0;
   int req_cnt = 0;
   logic [31:0] mem [0:255];

   ext_mem_loader #(.CNT_W(16)) dut (
      .clk(clk), .rst(rst),
      .cmd_val(cmd_val), .cmd_rdy(cmd_rdy), .cmd_op(cmd_op),
      .cmd_base(cmd_base), .cmd_count(cmd_count),
      .in_val(in_val), .in_rdy(in_rdy), .in_data(in_data),
      .out_val(out_val), .out_rdy(out_rdy), .out_data(out_data),
      .ext_dmemreq_val(ext_dmemreq_val), .ext_dmemreq_type(ext_dmemreq_type),
      .ext_dmemreq_addr(ext_dmemreq_addr), .ext_dmemreq_wdata(ext_dmemreq_wdata),
      .ext_dmemreq_rdata(ext_dmemreq_rdata),
      .busy(busy), .done(done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   assign ext_dmemreq_rdata = mem[ext_dmemreq_addr[9:2]];

   always @(posedge clk) begin
      if (ext_dmemreq_val && !rst) req_cnt <= req_cnt + 1;
      if (ext_dmemreq_val && ext_dmemreq_type) mem[ext_dmemreq_addr[9:2]] <= ext_dmemreq_wdata;
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // Present a command from posedge+1; it is accepted at the following posedge.
   task automatic send_cmd(input logic op, input logic [31:0] base, input logic [15:0] cnt);
      cmd_val = 1'b1; cmd_op = op; cmd_base = base; cmd_count = cnt;
      @(negedge clk);
      tests++;
      if (cmd_rdy !== 1'b1) begin fails++; $display("FAIL cmd_rdy got %b exp 1", cmd_rdy); end
      tick();
      cmd_val = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      tests++;
      if ({cmd_rdy, ext_dmemreq_val, in_rdy, out_val, busy, done} !== 6'b0) begin
         fails++; $display("FAIL reset_ctrl got %b exp 000000", {cmd_rdy, ext_dmemreq_val, in_rdy, out_val, busy, done});
      end
      tests++;
      if ({ext_dmemreq_addr, ext_dmemreq_wdata, out_data} !== 96'h0) begin
         fails++; $display("FAIL reset_data got %h %h %h exp 0", ext_dmemreq_addr, ext_dmemreq_wdata, out_data);
      end
      tick();
      rst = 1'b0;
      @(negedge clk);
      tests++;
      if (cmd_rdy !== 1'b1) begin fails++; $display("FAIL reset_release_rdy got %b exp 1", cmd_rdy); end
      tick();
   endtask

   task automatic test_load();
      logic [31:0] ea, ed;
      send_cmd(1'b0, 32'h200, 16'd3);
      for (int i = 0; i < 3; i++) begin
         in_val = 1'b1; in_data = 32'hA + i;
         ea = 32'h200 + 4 * i; ed = 32'hA + i;
         @(negedge clk);
         tests++;
         if ({ext_dmemreq_val, ext_dmemreq_type, ext_dmemreq_addr, ext_dmemreq_wdata, in_rdy, busy} !== {1'b1, 1'b1, ea, ed, 1'b1, 1'b1}) begin
            fails++; $display("FAIL load_write%0d got v=%b t=%b a=%h d=%h exp a=%h d=%h", i, ext_dmemreq_val, ext_dmemreq_type, ext_dmemreq_addr, ext_dmemreq_wdata, ea, ed);
         end
         tick();
      end
      in_val = 1'b0;
      @(negedge clk);
      tests++;
      if ({done, busy, ext_dmemreq_val, cmd_rdy, in_rdy} !== 5'b10000) begin
         fails++; $display("FAIL load_done got %b exp 10000", {done, busy, ext_dmemreq_val, cmd_rdy, in_rdy});
      end
      tick();
      @(negedge clk);
      tests++;
      if ({done, cmd_rdy} !== 2'b01) begin fails++; $display("FAIL load_idle got %b exp 01", {done, cmd_rdy}); end
      tick();
   endtask

   task automatic test_load_bubbles();
      logic [3:0] pat;
      int rc0;
      pat = 4'b1001;
      rc0 = req_cnt;
      send_cmd(1'b0, 32'h300, 16'd2);
      for (int i = 0; i < 4; i++) begin
         in_val = pat[3-i]; in_data = (i == 0) ? 32'h11 : 32'h22;
         @(negedge clk);
         tests++;
         if (ext_dmemreq_val !== pat[3-i]) begin
            fails++; $display("FAIL bubble_req%0d got %b exp %b", i, ext_dmemreq_val, pat[3-i]);
         end
         tick();
      end
      in_val = 1'b0;
      @(negedge clk);
      tests++;
      if (done !== 1'b1) begin fails++; $display("FAIL bubble_done got %b exp 1", done); end
      tick();
      tests++;
      if (req_cnt - rc0 !== 2) begin fails++; $display("FAIL bubble_count got %0d exp 2", req_cnt - rc0); end
      tests++;
      if ({mem[8'hC0], mem[8'hC1]} !== {32'h11, 32'h22}) begin
         fails++; $display("FAIL bubble_mem got %h %h exp 11 22", mem[8'hC0], mem[8'hC1]);
      end
   endtask

   task automatic test_dump();
      logic [31:0] got [0:3];
      int n, first, last, donec;
      n = 0; first = -1; last = -1; donec = 0;
      out_rdy = 1'b1;
      send_cmd(1'b1, 32'h200, 16'd3);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (out_val && out_rdy && n < 4) begin
            got[n] = out_data; n++;
            if (first < 0) first = c;
            last = c;
         end
         if (done) donec++;
         tick();
      end
      tests++;
      if (n !== 3) begin fails++; $display("FAIL dump_words got %0d exp 3", n); end
      else begin
         tests++;
         if ({got[0], got[1], got[2]} !== {32'hA, 32'hB, 32'hC}) begin
            fails++; $display("FAIL dump_data got %h %h %h exp a b c", got[0], got[1], got[2]);
         end
      end
      tests++;
      if ({first, last} !== {32'd1, 32'd3}) begin
         fails++; $display("FAIL dump_timing got first=%0d last=%0d exp 1 3", first, last);
      end
      tests++;
      if (donec !== 1) begin fails++; $display("FAIL dump_done got %0d exp 1", donec); end
   endtask

   task automatic test_dump_stall();
      logic [31:0] got [0:3];
      int rc0, n, donec;
      out_rdy = 1'b0;
      rc0 = req_cnt;
      send_cmd(1'b1, 32'h200, 16'd3);
      @(negedge clk);
      tests++;
      if ({ext_dmemreq_val, ext_dmemreq_type, ext_dmemreq_addr} !== {1'b1, 1'b0, 32'h200}) begin
         fails++; $display("FAIL stall_read got v=%b t=%b a=%h exp 1 0 200", ext_dmemreq_val, ext_dmemreq_type, ext_dmemreq_addr);
      end
      tick();
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         tests++;
         if ({out_val, out_data, ext_dmemreq_val} !== {1'b1, 32'hA, 1'b0}) begin
            fails++; $display("FAIL stall_hold%0d got ov=%b d=%h rv=%b exp 1 a 0", c, out_val, out_data, ext_dmemreq_val);
         end
         tick();
      end
      tests++;
      if (req_cnt - rc0 !== 1) begin fails++; $display("FAIL stall_reqs got %0d exp 1", req_cnt - rc0); end
      out_rdy = 1'b1;
      n = 0; donec = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (out_val && n < 4) begin got[n] = out_data; n++; end
         if (done) donec++;
         tick();
      end
      tests++;
      if ({n, donec} !== {32'd3, 32'd1}) begin
         fails++; $display("FAIL stall_drain got n=%0d done=%0d exp 3 1", n, donec);
      end else begin
         tests++;
         if ({got[0], got[1], got[2]} !== {32'hA, 32'hB, 32'hC}) begin
            fails++; $display("FAIL stall_data got %h %h %h exp a b c", got[0], got[1], got[2]);
         end
      end
   endtask

   task automatic test_zero_and_wrap();
      int rc0;
      logic [31:0] ea;
      rc0 = req_cnt;
      send_cmd(1'b0, 32'h1234_5678, 16'd0);
      @(negedge clk);
      tests++;
      if ({done, busy, ext_dmemreq_val, in_rdy} !== 4'b1000) begin
         fails++; $display("FAIL zero_done got %b exp 1000", {done, busy, ext_dmemreq_val, in_rdy});
      end
      tick();
      tests++;
      if (req_cnt !== rc0) begin fails++; $display("FAIL zero_traffic got %0d exp 0", req_cnt - rc0); end
      send_cmd(1'b0, 32'hFFFF_FFFD, 16'd2);
      for (int i = 0; i < 2; i++) begin
         in_val = 1'b1; in_data = 32'h55 + 32'h11 * i;
         ea = (i == 0) ? 32'hFFFF_FFFC : 32'h0;
         @(negedge clk);
         tests++;
         if ({ext_dmemreq_val, ext_dmemreq_addr} !== {1'b1, ea}) begin
            fails++; $display("FAIL wrap_addr%0d got v=%b a=%h exp 1 %h", i, ext_dmemreq_val, ext_dmemreq_addr, ea);
         end
         tick();
      end
      in_val = 1'b0;
      @(negedge clk);
      tests++;
      if (done !== 1'b1) begin fails++; $display("FAIL wrap_done got %b exp 1", done); end
      tick();
   endtask

   task automatic test_reset_mid_dump();
      out_rdy = 1'b0;
      send_cmd(1'b1, 32'h200, 16'd3);
      tick();
      @(negedge clk);
      tests++;
      if (out_val !== 1'b1) begin fails++; $display("FAIL rstmid_pre got %b exp 1", out_val); end
      #2 rst = 1'b1;
      #1;
      tests++;
      if ({out_val, ext_dmemreq_val, cmd_rdy, busy} !== 4'b0000) begin
         fails++; $display("FAIL rstmid_async got %b exp 0000", {out_val, ext_dmemreq_val, cmd_rdy, busy});
      end
      tick();
      tests++;
      if (ext_dmemreq_val !== 1'b0) begin fails++; $display("FAIL rstmid_noreq got %b exp 0", ext_dmemreq_val); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      tests++;
      if ({cmd_rdy, out_val} !== 2'b10) begin
         fails++; $display("FAIL rstmid_release got %b exp 10", {cmd_rdy, out_val});
      end
      tick();
   endtask

   initial begin
      rst = 1'b1; cmd_val = 1'b0; cmd_op = 1'b0; cmd_base = 32'h0; cmd_count = 16'h0;
      in_val = 1'b0; in_data = 32'h0; out_rdy = 1'b0;
      test_reset();
      test_load();
      test_load_bubbles();
      test_dump();
      test_dump_stall();
      test_zero_and_wrap();
      test_reset_mid_dump();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got running exp finished");
      $fatal(1, "timeout");
   end

endmodule
